// File: rtl/mem_stage_ctrl_if.sv
// Bus bundle for the dual-issue memory stage: EX/MEM slot requests, DM ports, MMIO bus, MEM/WB results.
// master = surrounding pipeline/memories, slave = mem_stage_ctrl.
interface mem_stage_ctrl_if #(
  parameter int DM_AW = 13,
  parameter int AW    = 16
);
  logic             flush;
  logic             vld0, vld1;
  logic             re0, re1;
  logic             we0, we1;
  logic [AW-1:0]    addr0, addr1;
  logic [31:0]      wdata0, wdata1;
  logic             stall;
  logic [DM_AW-1:0] dm_addr0, dm_addr1;
  logic             dm_re0, dm_re1, dm_we0, dm_we1;
  logic [31:0]      dm_wdata0, dm_wdata1;
  logic [31:0]      dm_rdata0, dm_rdata1;
  logic [AW-1:0]    mm_addr;
  logic [31:0]      mm_wdata;
  logic             mm_re, mm_we;
  logic [31:0]      mm_rdata;
  logic             wb_vld0, wb_vld1;
  logic [31:0]      wb_data0, wb_data1;
  logic             bnd_err;

  modport master (
    output flush, vld0, vld1, re0, re1, we0, we1, addr0, addr1, wdata0, wdata1,
    output dm_rdata0, dm_rdata1, mm_rdata,
    input  stall, dm_addr0, dm_addr1, dm_re0, dm_re1, dm_we0, dm_we1,
    input  dm_wdata0, dm_wdata1, mm_addr, mm_wdata, mm_re, mm_we,
    input  wb_vld0, wb_vld1, wb_data0, wb_data1, bnd_err
  );

  modport slave (
    input  flush, vld0, vld1, re0, re1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  dm_rdata0, dm_rdata1, mm_rdata,
    output stall, dm_addr0, dm_addr1, dm_re0, dm_re1, dm_we0, dm_we1,
    output dm_wdata0, dm_wdata1, mm_addr, mm_wdata, mm_re, mm_we,
    output wb_vld0, wb_vld1, wb_data0, wb_data1, bnd_err
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Dual-issue MEM stage: steers slot0/slot1 to dual-port DM or single-port MMIO, serialising dual MMIO.
// Optional: define DM_BOUNDS_CHECK_EN to flag and suppress DM accesses above the DM word range.
module mem_stage_ctrl #(
  parameter int DM_AW = 13,
  parameter int AW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_stage_ctrl_if.slave  bus
);

  typedef enum logic {S_IDLE, S_SECOND} state_t;

  state_t      r_state;
  logic        r_vld0, r_vld1;
  logic        r_ismm0, r_ismm1;
  logic        r_oob0, r_oob1;
  logic [31:0] r_hold0, r_hold1;

  logic w_act0, w_act1, w_mm0, w_mm1, w_oob0, w_oob1;
  logic w_idle, w_dual, w_mm_go, w_sel1;

  assign w_act0 = bus.vld0 & ~bus.flush & (bus.re0 | bus.we0);
  assign w_act1 = bus.vld1 & ~bus.flush & (bus.re1 | bus.we1);
  assign w_mm0  = bus.addr0[AW-1];
  assign w_mm1  = bus.addr1[AW-1];

`ifdef DM_BOUNDS_CHECK_EN
  assign w_oob0 = ~w_mm0 & (|bus.addr0[AW-2:DM_AW]);
  assign w_oob1 = ~w_mm1 & (|bus.addr1[AW-2:DM_AW]);
`else
  assign w_oob0 = 1'b0;
  assign w_oob1 = 1'b0;
`endif

  assign w_idle = (r_state == S_IDLE);
  assign w_dual = w_act0 & w_mm0 & w_act1 & w_mm1;

  // In SECOND the MMIO port belongs to the held slot1; otherwise slot0 wins when it is MMIO.
  assign w_sel1  = w_idle ? ~(w_act0 & w_mm0) : 1'b1;
  assign w_mm_go = w_idle ? ((w_act0 & w_mm0) | (w_act1 & w_mm1)) : (w_act1 & w_mm1);

  assign bus.mm_re    = rst_n & w_mm_go & (w_sel1 ? bus.re1 : bus.re0);
  assign bus.mm_we    = rst_n & w_mm_go & (w_sel1 ? bus.we1 : bus.we0);
  assign bus.mm_addr  = w_sel1 ? bus.addr1 : bus.addr0;
  assign bus.mm_wdata = w_sel1 ? bus.wdata1 : bus.wdata0;

  assign bus.dm_re0    = rst_n & w_idle & w_act0 & ~w_mm0 & ~w_oob0 & bus.re0;
  assign bus.dm_we0    = rst_n & w_idle & w_act0 & ~w_mm0 & ~w_oob0 & bus.we0;
  assign bus.dm_re1    = rst_n & w_idle & w_act1 & ~w_mm1 & ~w_oob1 & bus.re1;
  assign bus.dm_we1    = rst_n & w_idle & w_act1 & ~w_mm1 & ~w_oob1 & bus.we1;
  assign bus.dm_addr0  = bus.addr0[DM_AW-1:0];
  assign bus.dm_addr1  = bus.addr1[DM_AW-1:0];
  assign bus.dm_wdata0 = bus.wdata0;
  assign bus.dm_wdata1 = bus.wdata1;

  assign bus.stall = rst_n & w_idle & w_dual;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_vld0  <= 1'b0;
      r_vld1  <= 1'b0;
      r_ismm0 <= 1'b0;
      r_ismm1 <= 1'b0;
      r_oob0  <= 1'b0;
      r_oob1  <= 1'b0;
      r_hold0 <= '0;
      r_hold1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dual) begin
            r_hold0 <= bus.mm_rdata;
            r_vld0  <= 1'b0;
            r_vld1  <= 1'b0;
            r_oob0  <= 1'b0;
            r_oob1  <= 1'b0;
            r_state <= S_SECOND;
          end else begin
            r_vld0  <= w_act0 & bus.re0;
            r_vld1  <= w_act1 & bus.re1;
            r_ismm0 <= w_mm0;
            r_ismm1 <= w_mm1;
            r_oob0  <= w_act0 & w_oob0;
            r_oob1  <= w_act1 & w_oob1;
            if (w_act0 & w_mm0)
              r_hold0 <= bus.mm_rdata;
            else if (w_act1 & w_mm1)
              r_hold1 <= bus.mm_rdata;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_oob0  <= 1'b0;
          r_oob1  <= 1'b0;
          if (bus.flush) begin
            r_vld0  <= 1'b0;
            r_vld1  <= 1'b0;
            r_hold0 <= '0;
          end else begin
            r_vld0  <= w_act0 & bus.re0;
            r_vld1  <= w_act1 & bus.re1;
            r_ismm0 <= 1'b1;
            r_ismm1 <= 1'b1;
            r_hold1 <= bus.mm_rdata;
          end
        end
      endcase
    end
  end

`ifdef DM_BOUNDS_CHECK_EN
  logic r_bnd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_bnd <= 1'b0;
    else
      r_bnd <= w_idle & ~w_dual & ((w_act0 & w_oob0) | (w_act1 & w_oob1));
  end
  assign bus.bnd_err = r_bnd;
`else
  assign bus.bnd_err = 1'b0;
`endif

  // Results are zero unless valid; out-of-range loads complete with zero data.
  assign bus.wb_vld0  = r_vld0;
  assign bus.wb_vld1  = r_vld1;
  assign bus.wb_data0 = (!r_vld0 || r_oob0) ? 32'h0 : (r_ismm0 ? r_hold0 : bus.dm_rdata0);
  assign bus.wb_data1 = (!r_vld1 || r_oob1) ? 32'h0 : (r_ismm1 ? r_hold1 : bus.dm_rdata1);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: DM model returns 0xDA7A0000|word_addr one cycle after dm_re.
// Exercises dual DM, DM+MMIO, dual MMIO, flush in SECOND, async reset mid-SECOND, DM_BOUNDS_CHECK_EN.
module tb_mem_stage_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  mem_stage_ctrl_if #(.DM_AW(13), .AW(16)) bus();

  mem_stage_ctrl #(.DM_AW(13), .AW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (bus.dm_re0) bus.dm_rdata0 <= 32'hDA7A_0000 | {19'h0, bus.dm_addr0};
    if (bus.dm_re1) bus.dm_rdata1 <= 32'hDA7A_0000 | {19'h0, bus.dm_addr1};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    bus.flush = 1'b0;
    bus.vld0 = 1'b0; bus.vld1 = 1'b0;
    bus.re0 = 1'b0;  bus.re1 = 1'b0;
    bus.we0 = 1'b0;  bus.we1 = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    bus.mm_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_req();
    bus.dm_rdata0 = 32'h0;
    bus.dm_rdata1 = 32'h0;
    #3;
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_wbvld0", 32'(bus.wb_vld0), 0);
    chk("rst_wbdata0", bus.wb_data0, 0);
    chk("rst_bnd", 32'(bus.bnd_err), 0);
    @(negedge clk); rst_n = 1'b1;

    // dual DM load
    @(negedge clk);
    bus.vld0 = 1; bus.re0 = 1; bus.addr0 = 16'h0010;
    bus.vld1 = 1; bus.re1 = 1; bus.addr1 = 16'h0011;
    #1;
    chk("ddm_stall", 32'(bus.stall), 0);
    chk("ddm_dmre0", 32'(bus.dm_re0), 1);
    chk("ddm_dmre1", 32'(bus.dm_re1), 1);
    chk("ddm_dmaddr1", 32'(bus.dm_addr1), 32'h11);
    chk("ddm_mmre", 32'(bus.mm_re), 0);
    tick();
    chk("ddm_wbvld0", 32'(bus.wb_vld0), 1);
    chk("ddm_wbvld1", 32'(bus.wb_vld1), 1);
    chk("ddm_wbdata0", bus.wb_data0, 32'hDA7A_0010);
    chk("ddm_wbdata1", bus.wb_data1, 32'hDA7A_0011);

    // DM load slot0 + MMIO store slot1
    @(negedge clk); clear_req();
    bus.vld0 = 1; bus.re0 = 1; bus.addr0 = 16'h0004;
    bus.vld1 = 1; bus.we1 = 1; bus.addr1 = 16'h8002; bus.wdata1 = 32'hA5;
    #1;
    chk("mix_mmwe", 32'(bus.mm_we), 1);
    chk("mix_mmre", 32'(bus.mm_re), 0);
    chk("mix_mmaddr", 32'(bus.mm_addr), 32'h8002);
    chk("mix_mmwdata", bus.mm_wdata, 32'hA5);
    chk("mix_stall", 32'(bus.stall), 0);
    chk("mix_dmre0", 32'(bus.dm_re0), 1);
    chk("mix_dmwe1", 32'(bus.dm_we1), 0);
    tick();
    chk("mix_wbvld0", 32'(bus.wb_vld0), 1);
    chk("mix_wbdata0", bus.wb_data0, 32'hDA7A_0004);
    chk("mix_wbvld1", 32'(bus.wb_vld1), 0);

    // flush in IDLE kills both slots
    @(negedge clk); clear_req();
    bus.flush = 1; bus.vld0 = 1; bus.re0 = 1; bus.addr0 = 16'h0020;
    bus.vld1 = 1; bus.re1 = 1; bus.addr1 = 16'h8020;
    #1;
    chk("fl_dmre0", 32'(bus.dm_re0), 0);
    chk("fl_mmre", 32'(bus.mm_re), 0);
    tick();
    chk("fl_wbvld0", 32'(bus.wb_vld0), 0);
    chk("fl_wbvld1", 32'(bus.wb_vld1), 0);

    // dual MMIO load
    @(negedge clk); clear_req();
    bus.vld0 = 1; bus.re0 = 1; bus.addr0 = 16'h8000;
    bus.vld1 = 1; bus.re1 = 1; bus.addr1 = 16'h8001;
    bus.mm_rdata = 32'h11;
    #1;
    chk("dmm_stall_n", 32'(bus.stall), 1);
    chk("dmm_mmre_n", 32'(bus.mm_re), 1);
    chk("dmm_mmaddr_n", 32'(bus.mm_addr), 32'h8000);
    chk("dmm_dmre0_n", 32'(bus.dm_re0), 0);
    tick();
    chk("dmm_wbvld0_n1", 32'(bus.wb_vld0), 0);
    chk("dmm_wbvld1_n1", 32'(bus.wb_vld1), 0);
    @(negedge clk); bus.mm_rdata = 32'h22;
    #1;
    chk("dmm_stall_n1", 32'(bus.stall), 0);
    chk("dmm_mmre_n1", 32'(bus.mm_re), 1);
    chk("dmm_mmaddr_n1", 32'(bus.mm_addr), 32'h8001);
    tick();
    chk("dmm_wbvld0_n2", 32'(bus.wb_vld0), 1);
    chk("dmm_wbvld1_n2", 32'(bus.wb_vld1), 1);
    chk("dmm_wbdata0_n2", bus.wb_data0, 32'h11);
    chk("dmm_wbdata1_n2", bus.wb_data1, 32'h22);

    // dual MMIO with flush in SECOND
    @(negedge clk); clear_req();
    bus.vld0 = 1; bus.re0 = 1; bus.addr0 = 16'h8003;
    bus.vld1 = 1; bus.re1 = 1; bus.addr1 = 16'h8004;
    bus.mm_rdata = 32'h33;
    #1;
    chk("dfl_stall", 32'(bus.stall), 1);
    tick();
    @(negedge clk); bus.flush = 1;
    #1;
    chk("dfl_mmre2", 32'(bus.mm_re), 0);
    chk("dfl_stall2", 32'(bus.stall), 0);
    tick();
    chk("dfl_wbvld0", 32'(bus.wb_vld0), 0);
    chk("dfl_wbvld1", 32'(bus.wb_vld1), 0);
    @(negedge clk); clear_req();
    bus.vld0 = 1; bus.re0 = 1; bus.addr0 = 16'h8006; bus.mm_rdata = 32'h44;
    #1;
    chk("dfl_idle_mmre", 32'(bus.mm_re), 1);
    chk("dfl_idle_mmaddr", 32'(bus.mm_addr), 32'h8006);
    tick();
    chk("dfl_idle_wbvld0", 32'(bus.wb_vld0), 1);
    chk("dfl_idle_wbdata0", bus.wb_data0, 32'h44);

    // async reset while in SECOND
    @(negedge clk); clear_req();
    bus.vld0 = 1; bus.re0 = 1; bus.addr0 = 16'h8007;
    bus.vld1 = 1; bus.re1 = 1; bus.addr1 = 16'h8008;
    bus.mm_rdata = 32'h55;
    tick();
    @(negedge clk);
    #1;
    chk("rs_mmre_second", 32'(bus.mm_re), 1);
    rst_n = 1'b0;
    #1;
    chk("rs_stall", 32'(bus.stall), 0);
    chk("rs_mmre", 32'(bus.mm_re), 0);
    chk("rs_wbvld0", 32'(bus.wb_vld0), 0);
    chk("rs_wbdata0", bus.wb_data0, 0);
    clear_req();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    bus.vld0 = 1; bus.re0 = 1; bus.addr0 = 16'h0030;
    bus.vld1 = 1; bus.re1 = 1; bus.addr1 = 16'h0031;
    #1;
    chk("rs_post_stall", 32'(bus.stall), 0);
    tick();
    chk("rs_post_wbvld0", 32'(bus.wb_vld0), 1);
    chk("rs_post_wbdata0", bus.wb_data0, 32'hDA7A_0030);
    chk("rs_post_wbdata1", bus.wb_data1, 32'hDA7A_0031);

    // DM access with upper address bits set
    @(negedge clk); clear_req();
    bus.vld0 = 1; bus.re0 = 1; bus.addr0 = 16'h2000;
    #1;
`ifdef DM_BOUNDS_CHECK_EN
    chk("bnd_dmre0", 32'(bus.dm_re0), 0);
    tick();
    chk("bnd_wbvld0", 32'(bus.wb_vld0), 1);
    chk("bnd_wbdata0", bus.wb_data0, 0);
    chk("bnd_err", 32'(bus.bnd_err), 1);
    @(negedge clk); clear_req();
    tick();
    chk("bnd_err_pulse", 32'(bus.bnd_err), 0);
`else
    chk("alias_dmre0", 32'(bus.dm_re0), 1);
    chk("alias_dmaddr0", 32'(bus.dm_addr0), 0);
    tick();
    chk("alias_wbvld0", 32'(bus.wb_vld0), 1);
    chk("alias_wbdata0", bus.wb_data0, 32'hDA7A_0000);
    chk("alias_bnd", 32'(bus.bnd_err), 0);
`endif

    @(negedge clk); clear_req();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
